aes_word_serializer: RTL and testbench

- Inverse of the 32-to-256-bit seed gather path. Takes one 256-bit block (AES-256 key/result block) on a single-cycle load and emits it as eight 32-bit words over a valid/ready stream.
- Sits at the output side of the AES256 IP core, between the core's 256-bit result register and the 32-bit bus interface.

---
 rtl/aes_ip_pkg.sv | 15 +
 rtl/aes_word_serializer.sv | 96 +++++++++
 tb/tb_aes_word_serializer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/aes_ip_pkg.sv
// Shared constants and state encoding for the AES256 IP datapath blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package aes_ip_pkg;

    localparam int AES_BLOCK_WH = 256;
    localparam int BUS_WH       = 32;
    localparam int NUM_WORDS    = AES_BLOCK_WH / BUS_WH;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/aes_word_serializer.sv
// Serializes one 256-bit AES block into eight 32-bit words, least-significant word first.
// Latency: first word valid 1 cycle after an accepted load; one word per cycle with ready_in high.
// Backpressure: word held stable while ready_in is low; loads are refused (load_drop) unless idle or on the last transfer.
//
// Ports:
//   clk, resetn          clock and synchronous active-low reset
//   load_in, data_in     single-cycle block load request and 256-bit block
//   load_ready           combinational: a load presented this cycle is accepted
//   load_drop            1-cycle pulse after a refused load
//   data_out, valid_out  current output word and its valid flag
//   ready_in             downstream accept
//   busy, words_left     block in flight and words still to transfer
//   done                 1-cycle pulse after the last word of a block transfers
module aes_word_serializer
    import aes_ip_pkg::*;
#(
    parameter int DATA_IN_WH  = AES_BLOCK_WH,
    parameter int DATA_OUT_WH = BUS_WH,
    parameter int CNT_WH      = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   load_in,
    input  logic [DATA_IN_WH-1:0]  data_in,
    output logic                   load_ready,
    output logic                   load_drop,
    output logic [DATA_OUT_WH-1:0] data_out,
    output logic                   valid_out,
    input  logic                   ready_in,
    output logic                   busy,
    output logic [CNT_WH-1:0]      words_left,
    output logic                   done
);

    localparam int WORDS  = DATA_IN_WH / DATA_OUT_WH;
    localparam int IDX_WH = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_t                  r_state;
    logic [DATA_IN_WH-1:0]   r_shift;
    logic [IDX_WH-1:0]       r_idx;
    logic [CNT_WH-1:0]       r_words_left;
    logic                    r_done;
    logic                    r_load_drop;

    logic w_xfer;
    logic w_last;
    logic w_load_ready;
    logic w_load;

    // valid_out is high exactly while in SEND, so a transfer implies SEND.
    assign w_xfer       = (r_state == SEND) & ready_in;
    assign w_last       = w_xfer & (r_idx == IDX_WH'(WORDS - 1));
    assign w_load_ready = (r_state == IDLE) | w_last;
    assign w_load       = load_in & w_load_ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_idx        <= '0;
            r_words_left <= '0;
            r_done       <= 1'b0;
            r_load_drop  <= 1'b0;
        end else begin
            r_load_drop <= load_in & ~w_load_ready;
            // done fires on every last transfer, including the back-to-back case.
            r_done      <= w_last;

            if (w_load) begin
                r_state      <= SEND;
                r_shift      <= data_in;
                r_idx        <= '0;
                r_words_left <= CNT_WH'(WORDS);
            end else if (w_xfer) begin
                // Shifting in zeros leaves data_out at 0 once the block is drained.
                r_shift      <= {DATA_OUT_WH'(0), r_shift[DATA_IN_WH-1:DATA_OUT_WH]};
                r_words_left <= r_words_left - CNT_WH'(1);
                if (w_last) begin
                    r_state <= IDLE;
                    r_idx   <= '0;
                end else begin
                    r_idx   <= r_idx + IDX_WH'(1);
                end
            end
        end
    end

    assign load_ready = w_load_ready;
    assign load_drop  = r_load_drop;
    assign data_out   = r_shift[DATA_OUT_WH-1:0];
    assign valid_out  = (r_state == SEND);
    assign busy       = (r_state == SEND);
    assign words_left = r_words_left;
    assign done       = r_done;

endmodule

// File: tb/tb_aes_word_serializer.sv
// Self-checking bench for aes_word_serializer against a queue-based block/word model.
// Latency: n/a.
// Backpressure: exercised via directed and random ready_in patterns.
module tb_aes_word_serializer;

    logic         clk;
    logic         resetn;
    logic         load_in;
    logic [255:0] data_in;
    logic         load_ready;
    logic         load_drop;
    logic [31:0]  data_out;
    logic         valid_out;
    logic         ready_in;
    logic         busy;
    logic [3:0]   words_left;
    logic         done;

    aes_word_serializer dut (
        .clk        (clk),
        .resetn     (resetn),
        .load_in    (load_in),
        .data_in    (data_in),
        .load_ready (load_ready),
        .load_drop  (load_drop),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .busy       (busy),
        .words_left (words_left),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: words still owed to the downstream, oldest first.
    logic [31:0] q[$];
    logic        exp_done = 1'b0;
    logic        exp_drop = 1'b0;

    logic [255:0] blk_a;
    logic [255:0] blk_b;

    function automatic logic [255:0] mk_block(input logic [31:0] base);
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = base + 32'(k);
        return v;
    endfunction

    function automatic logic [255:0] rand_block();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, compare outputs against
    // the model, then advance the model as the DUT will at the next rising edge.
    task automatic step(input logic rst_n, input logic ld, input logic [255:0] d,
                        input logic rdy, input bit do_chk);
        bit pending;
        bit lr;
        bit xfer;
        bit last;
        @(negedge clk);
        resetn   = rst_n;
        load_in  = ld;
        data_in  = d;
        ready_in = rdy;
        #1;
        pending = (q.size() != 0);
        xfer    = pending && rdy;
        last    = xfer && (q.size() == 1);
        lr      = !pending || last;
        if (do_chk) begin
            chk("valid_out",  32'(valid_out),  32'(pending));
            chk("busy",       32'(busy),       32'(pending));
            chk("data_out",   data_out,        pending ? q[0] : 32'h0);
            chk("words_left", 32'(words_left), 32'(q.size()));
            chk("done",       32'(done),       32'(exp_done));
            chk("load_drop",  32'(load_drop),  32'(exp_drop));
            chk("load_ready", 32'(load_ready), 32'(lr));
        end
        if (!rst_n) begin
            q.delete();
            exp_done = 1'b0;
            exp_drop = 1'b0;
        end else begin
            if (xfer) void'(q.pop_front());
            exp_done = last;
            exp_drop = ld && !lr;
            if (ld && lr)
                for (int k = 0; k < 8; k++) q.push_back(d[k*32 +: 32]);
        end
    endtask

    // Keep ready_in high with no loads until at most n words remain.
    task automatic drain_to(input int n);
        for (int i = 0; i < 40; i++) begin
            if (q.size() <= n) break;
            step(1'b1, 1'b0, rand_block(), 1'b1, 1'b1);
        end
    endtask

    initial begin
        resetn   = 1'b0;
        load_in  = 1'b0;
        data_in  = '0;
        ready_in = 1'b0;
        blk_a    = mk_block(32'hA0A0_0000);
        blk_b    = mk_block(32'hB0B0_0000);

        // Reset, then check the reset state.
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b1);

        // Single block, ready held high.
        step(1'b1, 1'b1, blk_a, 1'b1, 1'b1);
        drain_to(0);
        step(1'b1, 1'b0, '0, 1'b1, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1, 1'b1);

        // Backpressure: ready pattern 1,0,0 repeating.
        step(1'b1, 1'b1, blk_a, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            if (q.size() == 0) break;
            step(1'b1, 1'b0, rand_block(), (i % 3) == 0, 1'b1);
        end
        step(1'b1, 1'b0, '0, 1'b0, 1'b1);

        // Back-to-back: block B loaded during the last transfer of block A.
        step(1'b1, 1'b1, blk_a, 1'b1, 1'b1);
        drain_to(1);
        step(1'b1, 1'b1, blk_b, 1'b1, 1'b1);
        drain_to(0);
        step(1'b1, 1'b0, '0, 1'b1, 1'b1);

        // Overrun: load while word 3 is pending.
        step(1'b1, 1'b1, blk_a, 1'b1, 1'b1);
        drain_to(5);
        step(1'b1, 1'b1, blk_b, 1'b0, 1'b1);
        drain_to(0);
        step(1'b1, 1'b0, '0, 1'b1, 1'b1);

        // Reset after word 2 transfers, then a fresh load.
        step(1'b1, 1'b1, blk_a, 1'b1, 1'b1);
        drain_to(5);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1, 1'b1);
        step(1'b1, 1'b1, blk_b, 1'b1, 1'b1);
        drain_to(0);
        step(1'b1, 1'b0, '0, 1'b1, 1'b1);

        // Idle noise: ready and data wiggle, no load.
        for (int i = 0; i < 20; i++)
            step(1'b1, 1'b0, rand_block(), 1'($urandom_range(0, 1)), 1'b1);

        // Random traffic: random loads, data and ready.
        for (int i = 0; i < 400; i++)
            step(1'b1, ($urandom_range(0, 3) == 0), rand_block(),
                 ($urandom_range(0, 3) != 0), 1'b1);
        drain_to(0);
        step(1'b1, 1'b0, '0, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
